// File: rtl/demux4_pkg.sv
// Shared definitions for the 4-channel demux collector: channel count,
// channel-index type and output-register state encoding.
package demux4_pkg;
  localparam int CH_NUM = 4;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;
endpackage

// File: rtl/demux4_ch_shifter.sv
// One channel's serial-to-parallel shift register and bit counter; reports
// the completed word combinationally in the cycle its last bit is accepted.
module demux4_ch_shifter #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_bit,
  output logic [DATA_W-1:0] o_word,
  output logic              o_done
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (i_en) begin
      // After DATA_W shifts the first bit sits at the far end of the word.
      if (MSB_FIRST) sh_d = (sh_q << 1) | DATA_W'(i_bit);
      else           sh_d = (sh_q >> 1) | (DATA_W'(i_bit) << (DATA_W - 1));
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign o_done = i_en && (cnt_q == CNT_LAST);
  assign o_word = sh_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/demux4_collector.sv
// Collects serial bits from the four outputs of a 1-to-4 demux into per-channel
// words and presents completed words through a one-entry valid/ready register.
module demux4_collector
  import demux4_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [1:0]        i_sel,
  input  logic              i_a,
  input  logic              i_b,
  input  logic              i_c,
  input  logic              i_d,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_ch,
  output logic              o_vld,
  input  logic              i_rdy,
  output logic              o_ovf
);
  logic [CH_NUM-1:0] lines_w;
  logic [CH_NUM-1:0] done_w;
  logic [DATA_W-1:0] word_w [CH_NUM];
  logic              comp_w;
  logic [DATA_W-1:0] comp_word_w;

  assign lines_w = {i_d, i_c, i_b, i_a};

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    demux4_ch_shifter #(
      .DATA_W   (DATA_W),
      .MSB_FIRST(MSB_FIRST)
    ) u_shifter (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (i_valid && (i_sel == ch_idx_t'(k))),
      .i_bit (lines_w[k]),
      .o_word(word_w[k]),
      .o_done(done_w[k])
    );
  end

  // At most one channel is enabled per cycle, so the selected one is the completer.
  assign comp_w      = |done_w;
  assign comp_word_w = word_w[i_sel];

  out_state_e        state_q;
  logic [DATA_W-1:0] data_q;
  ch_idx_t           ch_q;
  logic              ovf_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (comp_w) begin
            data_q  <= comp_word_w;
            ch_q    <= i_sel;
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (i_rdy) begin
            if (comp_w) begin
              data_q <= comp_word_w;
              ch_q   <= i_sel;
            end else begin
              state_q <= ST_EMPTY;
            end
          end else if (comp_w) begin
            // Held word wins; the newcomer is dropped and flagged.
            ovf_q <= 1'b1;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign o_vld  = (state_q == ST_FULL);
  assign o_data = data_q;
  assign o_ch   = ch_q;
  assign o_ovf  = ovf_q;
endmodule

// File: tb/tb_demux4_collector.sv
// Bench for demux4_collector: directed scenarios plus random traffic, with a
// queue-based reference of per-channel bit streams and a scoreboard monitor.
module tb_demux4_collector;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, valid, rdy;
  logic [1:0]    sel;
  logic [3:0]    ln;
  logic [DW-1:0] data_m, data_l;
  logic [1:0]    ch_m, ch_l;
  logic          vld_m, vld_l, ovf_m, ovf_l;

  always #5 clk = ~clk;

  demux4_collector #(.DATA_W(DW), .MSB_FIRST(1'b1)) u_msb (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_sel(sel),
    .i_a(ln[0]), .i_b(ln[1]), .i_c(ln[2]), .i_d(ln[3]),
    .o_data(data_m), .o_ch(ch_m), .o_vld(vld_m), .i_rdy(rdy), .o_ovf(ovf_m)
  );

  demux4_collector #(.DATA_W(DW), .MSB_FIRST(1'b0)) u_lsb (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_sel(sel),
    .i_a(ln[0]), .i_b(ln[1]), .i_c(ln[2]), .i_d(ln[3]),
    .o_data(data_l), .o_ch(ch_l), .o_vld(vld_l), .i_rdy(rdy), .o_ovf(ovf_l)
  );

  typedef struct {
    logic [1:0]    ch;
    logic [DW-1:0] wm;
    logic [DW-1:0] wl;
  } exp_t;

  bit   chq [4][$];
  exp_t sb[$];
  bit   exp_full, exp_ovf;
  bit   mon_en = 1'b0;
  int   total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: each channel is a list of received bits; a word is born when a
  // list reaches DW entries, and the single output slot accepts or drops it.
  task automatic model_edge();
    bit   comp = 1'b0;
    exp_t e;
    if (rst) begin
      for (int k = 0; k < 4; k++) chq[k].delete();
      sb.delete();
      exp_full = 1'b0;
      exp_ovf  = 1'b0;
      return;
    end
    if (valid) begin
      chq[sel].push_back(ln[sel]);
      if (chq[sel].size() == DW) begin
        comp = 1'b1;
        e.ch = sel;
        for (int i = 0; i < DW; i++) begin
          e.wm[DW-1-i] = chq[sel][i];
          e.wl[i]      = chq[sel][i];
        end
        chq[sel].delete();
      end
    end
    if (comp) begin
      if (exp_full && !rdy) exp_ovf = 1'b1;
      else begin
        sb.push_back(e);
        exp_full = 1'b1;
      end
    end else if (exp_full && rdy) begin
      exp_full = 1'b0;
    end
  endtask

  task automatic step(input logic v, input logic [1:0] s, input logic [3:0] l,
                      input logic r, input logic rs);
    valid = v; sel = s; ln = l; rdy = r; rst = rs;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send(input int ch, input logic [31:0] bits, input int n, input logic r);
    logic [3:0] l;
    for (int i = n - 1; i >= 0; i--) begin
      l = 4'($urandom);
      l[ch] = bits[i];
      step(1'b1, 2'(ch), l, r, 1'b0);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 2'd0, 4'($urandom), 1'b0, 1'b1);
    step(1'b0, 2'd0, 4'd0, 1'b1, 1'b0);
  endtask

  // Monitor: flags, and the presented word against the scoreboard head.
  initial begin
    exp_t h;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("vld", {31'd0, vld_m}, {31'd0, exp_full});
        chk("vld_lsb", {31'd0, vld_l}, {31'd0, exp_full});
        chk("ovf", {31'd0, ovf_m}, {31'd0, exp_ovf});
        chk("ovf_lsb", {31'd0, ovf_l}, {31'd0, exp_ovf});
        if (vld_m) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_empty: got word %0h expected none at %0t", data_m, $time);
          end else begin
            h = sb[0];
            chk("data_msb", 32'(data_m), 32'(h.wm));
            chk("data_lsb", 32'(data_l), 32'(h.wl));
            chk("ch", 32'(ch_m), 32'(h.ch));
            chk("ch_lsb", 32'(ch_l), 32'(h.ch));
            if (rdy) void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    valid = 1'b0; sel = 2'd0; ln = 4'd0; rdy = 1'b0; rst = 1'b1;
    exp_full = 1'b0; exp_ovf = 1'b0;
    step(1'b0, 2'd0, 4'd0, 1'b0, 1'b1);
    step(1'b1, 2'd1, 4'hF, 1'b1, 1'b1);
    mon_en = 1'b1;
    chk("rst_data", 32'(data_m), 32'd0);
    chk("rst_ch", 32'(ch_m), 32'd0);
    chk("rst_vld", {31'd0, vld_m}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_m}, 32'd0);

    // Single word on channel 0, first bit to MSB.
    send(0, 32'hA5, 8, 1'b1);
    chk("a5_vld", {31'd0, vld_m}, 32'd1);
    chk("a5_data", 32'(data_m), 32'hA5);
    chk("a5_ch", 32'(ch_m), 32'd0);
    step(1'b0, 2'd0, 4'd0, 1'b1, 1'b0);
    chk("a5_pulse", {31'd0, vld_m}, 32'd0);

    // Interleave: partial ch1 survives a full ch2 word.
    send(1, 32'hC, 4, 1'b1);
    send(2, 32'h3E, 8, 1'b1);
    chk("il_ch2", 32'(ch_m), 32'd2);
    chk("il_data2", 32'(data_m), 32'h3E);
    send(1, 32'h9, 4, 1'b1);
    chk("il_ch1", 32'(ch_m), 32'd1);
    chk("il_data1", 32'(data_m), 32'hC9);

    // Overflow: held ch3 word survives a ch0 completion.
    do_reset();
    send(3, 32'h5A, 8, 1'b0);
    send(0, 32'hFF, 8, 1'b0);
    chk("ovf_flag", {31'd0, ovf_m}, 32'd1);
    chk("ovf_held", 32'(data_m), 32'h5A);
    chk("ovf_ch", 32'(ch_m), 32'd3);
    step(1'b0, 2'd0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 2'd0, 4'd0, 1'b1, 1'b0);
    chk("ovf_single", {31'd0, vld_m}, 32'd0);
    chk("ovf_sticky", {31'd0, ovf_m}, 32'd1);

    // Accept and reload in the same cycle.
    do_reset();
    send(0, 32'h11, 8, 1'b0);
    send(1, 32'h11, 7, 1'b0);
    send(1, 32'h0, 1, 1'b1);
    chk("reload_vld", {31'd0, vld_m}, 32'd1);
    chk("reload_data", 32'(data_m), 32'h22);
    chk("reload_ch", 32'(ch_m), 32'd1);
    chk("reload_ovf", {31'd0, ovf_m}, 32'd0);

    // Reset with a held word and a partial ch2 word.
    do_reset();
    send(0, 32'h77, 8, 1'b0);
    send(2, 32'h15, 5, 1'b0);
    step(1'b0, 2'd0, 4'd0, 1'b0, 1'b1);
    chk("mr_vld", {31'd0, vld_m}, 32'd0);
    chk("mr_data", 32'(data_m), 32'd0);
    chk("mr_ch", 32'(ch_m), 32'd0);
    send(2, 32'hB4, 8, 1'b1);
    chk("mr_fresh", 32'(data_m), 32'hB4);
    chk("mr_fresh_ch", 32'(ch_m), 32'd2);

    // Idle traffic with i_valid low changes nothing.
    do_reset();
    send(0, 32'h5, 3, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 2'($urandom), 4'($urandom), 1'b1, 1'b0);
    send(0, 32'h13, 5, 1'b1);
    chk("idle_word", 32'(data_m), 32'hB3);
    chk("idle_vld", {31'd0, vld_m}, 32'd1);

    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++)
      step(($urandom % 4) != 0, 2'($urandom), 4'($urandom),
           ($urandom % 3) != 0, ($urandom % 600) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
